// File: rtl/bcd_operand_entry_pkg.sv
// bcd_operand_entry_pkg: shared FSM encodings, cursor and BCD constants
package bcd_operand_entry_pkg;
  typedef enum logic [2:0] {
    ST_EDIT_D0 = 3'd0,
    ST_EDIT_D1 = 3'd1,
    ST_EDIT_D2 = 3'd2,
    ST_EDIT_D3 = 3'd3,
    ST_EDIT_OP = 3'd4,
    ST_READY   = 3'd5
  } state_t;
  localparam logic [2:0] CURSOR_NONE = 3'd7;
  localparam logic [3:0] BCD_MAX = 4'd9;
  function automatic logic [3:0] bcd_inc(input logic [3:0] d);
    return (d >= BCD_MAX) ? 4'd0 : d + 4'd1;
  endfunction
endpackage

// File: rtl/bcd_operand_entry_button_debounce.sv
// button_debounce: synchronise, debounce and edge-detect one raw button into a 1-cycle press pulse
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W = 19
) (
  input  logic CLOCK_50,
  input  logic reset,
  input  logic raw,
  output logic press
);
  logic r_s0, r_s1, r_level, r_prev, r_armed, r_press;
  logic [CNT_W-1:0] r_cnt;
  logic w_diff;
  // Until armed, the button must be seen released for a full debounce window, so a
  // button held through reset cannot produce a press when reset drops.
  assign w_diff = r_armed ? (r_s1 != r_level) : r_s1 == 1'b0;
  assign press = r_press;
  // Sync chain, debounce counter, accepted level and registered rising-edge pulse
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_s0 <= 1'b0;
      r_s1 <= 1'b0;
      r_level <= 1'b0;
      r_prev <= 1'b0;
      r_armed <= 1'b0;
      r_press <= 1'b0;
      r_cnt <= '0;
    end else begin
      r_s0 <= raw;
      r_s1 <= r_s0;
      if (!w_diff) r_cnt <= '0;
      else if (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        r_cnt <= '0;
        if (r_armed) r_level <= r_s1;
        else r_armed <= 1'b1;
      end else r_cnt <= r_cnt + 1'b1;
      r_prev <= r_level;
      r_press <= r_level & ~r_prev;
    end
  end
endmodule

// File: rtl/bcd_operand_entry.sv
// bcd_operand_entry: three-button sequential entry of two 2-digit BCD operands and an operator
module bcd_operand_entry
  import bcd_operand_entry_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W = 19
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       btn_inc,
  input  logic       btn_next,
  input  logic       btn_enter,
  output logic [3:0] in1_10,
  output logic [3:0] in1_1,
  output logic [3:0] in2_10,
  output logic [3:0] in2_1,
  output logic       operator,
  output logic [2:0] cursor,
  output logic       operands_valid,
  output logic       load
);
  logic w_inc, w_next, w_enter;
  state_t r_state;
  logic [3:0] r_d0, r_d1, r_d2, r_d3;
  logic r_op, r_valid, r_load;
  logic [2:0] r_cursor;
  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_inc (
    .CLOCK_50(CLOCK_50), .reset(reset), .raw(btn_inc), .press(w_inc));
  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_next (
    .CLOCK_50(CLOCK_50), .reset(reset), .raw(btn_next), .press(w_next));
  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_enter (
    .CLOCK_50(CLOCK_50), .reset(reset), .raw(btn_enter), .press(w_enter));
  assign in1_10 = r_d0;
  assign in1_1 = r_d1;
  assign in2_10 = r_d2;
  assign in2_1 = r_d3;
  assign operator = r_op;
  assign cursor = r_cursor;
  assign operands_valid = r_valid;
  assign load = r_load;
  // Entry FSM: enter beats next beats inc; in edit states cursor mirrors the state code
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_state <= ST_EDIT_D0;
      r_d0 <= 4'd0;
      r_d1 <= 4'd0;
      r_d2 <= 4'd0;
      r_d3 <= 4'd0;
      r_op <= 1'b0;
      r_cursor <= 3'd0;
      r_valid <= 1'b0;
      r_load <= 1'b0;
    end else begin
      r_load <= 1'b0;
      if (r_state == ST_READY) begin
        if (w_next) begin
          r_state <= ST_EDIT_D0;
          r_cursor <= 3'd0;
          r_valid <= 1'b0;
        end
      end else if (w_enter) begin
        r_state <= ST_READY;
        r_cursor <= CURSOR_NONE;
        r_valid <= 1'b1;
        r_load <= 1'b1;
      end else if (w_next) begin
        r_state <= (r_state == ST_EDIT_OP) ? ST_EDIT_D0 : state_t'(r_state + 3'd1);
        r_cursor <= (r_state == ST_EDIT_OP) ? 3'd0 : r_cursor + 3'd1;
      end else if (w_inc) begin
        case (r_state)
          ST_EDIT_D0: r_d0 <= bcd_inc(r_d0);
          ST_EDIT_D1: r_d1 <= bcd_inc(r_d1);
          ST_EDIT_D2: r_d2 <= bcd_inc(r_d2);
          ST_EDIT_D3: r_d3 <= bcd_inc(r_d3);
          ST_EDIT_OP: r_op <= ~r_op;
          default: ;
        endcase
      end
    end
  end
endmodule
